// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_host_tx_pkg                                               |
// | Purpose  : Shared types and constants for the PS/2 host-to-device        |
// |            transmitter: FSM state encoding, frame geometry, common       |
// |            keyboard command bytes and a frame-bit lookup helper.         |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  // Device falling edges in one host-to-device frame (10 bits + ACK bit).
  localparam int FRAME_FALLS = 11;
  // Fall after which the stop bit is presented.
  localparam int STOP_FALL   = 10;
  // Cycles the start bit overlaps the clock inhibit before clock release.
  localparam int START_HOLD_CYCLES = 2;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  // Bit presented on the wire after fall number idx:
  // 0 = start, 1..8 = d0..d7, 9 = odd parity, 10 = stop.
  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
    logic [10:0] frame;
    frame = {1'b1, ~^data, data, 1'b0};
    if (idx <= 4'd10) begin
      return frame[idx];
    end
    return 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_host_tx_if                                                |
// | Purpose  : Command handshake and status bundle of the PS/2 transmitter.  |
// | Ports    : tx_data/tx_valid (request), tx_ready (accept window),         |
// |            busy, done (1-cycle pulse), ack_ok (qualifies done).          |
// |            master = command issuer, slave = transmitter.                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_ok;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_ok
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_ok
  );
endinterface
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_line_filter                                               |
// | Purpose  : 2-FF synchronizer followed by a stability filter for one      |
// |            open-drain PS/2 line. The output only follows the input after |
// |            FILTER_LEN consecutive equal synchronized samples.            |
// | Ports    : clk, rst (async, active low), line_i (raw pin),               |
// |            level_o (filtered level).                                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o
);

  localparam int              CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = line_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Count samples that disagree with the current level; any agreeing
    // sample restarts the run.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Lines idle high (pull-ups), so everything resets to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_host_tx                                                   |
// | Purpose  : PS/2 host-to-device transmitter. Inhibits the bus, issues a   |
// |            start bit, shifts one command byte (LSB first, odd parity,    |
// |            stop) on device clock falls and reports the device ACK.       |
// | Ports    : clk, rst (async, active low)                                  |
// |            bus            : ps2_host_tx_if.slave (command/status)        |
// |            ps2_clk_i/ps2_data_i        : raw pin levels                  |
// |            ps2_clk_drive/ps2_data_drive: 1 = pull line low               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic           clk,
  input  logic           rst,
  ps2_host_tx_if.slave   bus,
  input  logic           ps2_clk_i,
  input  logic           ps2_data_i,
  output logic           ps2_clk_drive,
  output logic           ps2_data_drive
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The start-bit hold is part of the clock-low period, so the INHIBIT
  // state itself is shortened by the hold length.
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - START_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [3:0]       bit_cnt_q,    bit_cnt_d;
  logic [7:0]       byte_q,       byte_d;
  logic             data_drive_q, data_drive_d;
  logic             ack_q,        ack_d;
  logic             clk_prev_q,   clk_prev_d;

  logic       clk_level;
  logic       data_level;
  logic       clk_fall;
  logic       accept;
  logic [3:0] bit_cnt_inc;
  logic       timeout_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2_clk_i),
    .level_o (clk_level)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2_data_i),
    .level_o (data_level)
  );

  assign clk_fall    = clk_prev_q & ~clk_level;
  assign accept      = bus.tx_valid && (state_q == ST_IDLE);
  assign bit_cnt_inc = bit_cnt_q + 4'd1;
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    byte_d       = byte_q;
    data_drive_d = data_drive_q;
    ack_d        = ack_q;
    clk_prev_d   = clk_level;

    case (state_q)
      ST_IDLE: begin
        cnt_d        = '0;
        bit_cnt_d    = '0;
        data_drive_d = 1'b0;
        if (accept) begin
          byte_d  = bus.tx_data;
          ack_d   = 1'b0;
          state_d = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d        = '0;
          data_drive_d = 1'b1;   // start bit, held until fall 1
          state_d      = ST_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_START: begin
        if (cnt_q == START_LAST) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (clk_fall) begin
          cnt_d        = '0;
          bit_cnt_d    = bit_cnt_inc;
          data_drive_d = ~frame_bit(byte_q, bit_cnt_inc);
          if (bit_cnt_inc == 4'(STOP_FALL)) begin
            state_d = ST_ACK;
          end
        end else if (timeout_hit) begin
          cnt_d        = '0;
          data_drive_d = 1'b0;
          ack_d        = 1'b0;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_ACK: begin
        if (clk_fall) begin
          cnt_d     = '0;
          bit_cnt_d = 4'(FRAME_FALLS);
          ack_d     = ~data_level;   // device pulls data low to ACK
          state_d   = ST_WAIT_IDLE;
        end else if (timeout_hit) begin
          cnt_d        = '0;
          data_drive_d = 1'b0;
          ack_d        = 1'b0;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_level && data_level) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (timeout_hit) begin
          cnt_d   = '0;
          ack_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        cnt_d        = '0;
        data_drive_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // Asynchronous reset releases both lines at once: clk_drive decodes the
  // state register and data_drive is itself a reset flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      byte_q       <= '0;
      data_drive_q <= 1'b0;
      ack_q        <= 1'b0;
      clk_prev_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_q       <= byte_d;
      data_drive_q <= data_drive_d;
      ack_q        <= ack_d;
      clk_prev_q   <= clk_prev_d;
    end
  end

  assign ps2_clk_drive  = (state_q == ST_INHIBIT) || (state_q == ST_START);
  assign ps2_data_drive = data_drive_q;

  assign bus.tx_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.ack_ok   = (state_q == ST_DONE) && ack_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ps2_host_tx                                                |
// | Purpose  : Directed self-checking bench for ps2_host_tx with a simple    |
// |            PS/2 device model (10-cycle half periods, optional ACK).      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if u_if ();

  logic ps2_clk_drive;
  logic ps2_data_drive;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_pin;
  logic ps2_data_pin;

  // Open-drain bus with pull-ups.
  assign ps2_clk_pin  = ~(ps2_clk_drive | dev_clk_low);
  assign ps2_data_pin = ~(ps2_data_drive | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (20),
    .TIMEOUT_CYCLES (200),
    .FILTER_LEN     (2)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (u_if),
    .ps2_clk_i      (ps2_clk_pin),
    .ps2_data_i     (ps2_data_pin),
    .ps2_clk_drive  (ps2_clk_drive),
    .ps2_data_drive (ps2_data_drive)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Done-pulse and clock-inhibit length monitors.
  int   done_cnt     = 0;
  logic last_ack     = 1'b0;
  int   clk_run      = 0;
  int   last_clk_run = 0;

  always @(negedge clk) begin
    if (u_if.done) begin
      done_cnt <= done_cnt + 1;
      last_ack <= u_if.ack_ok;
    end
    if (ps2_clk_drive) begin
      clk_run <= clk_run + 1;
    end else if (clk_run != 0) begin
      last_clk_run <= clk_run;
      clk_run      <= 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    while (!u_if.tx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check_val("send_ready_timeout", 32'd0, 32'd1);
    u_if.tx_data  = b;
    u_if.tx_valid = 1'b1;
    @(negedge clk);
    u_if.tx_valid = 1'b0;
  endtask

  // Device model: waits for the start bit with the clock released, samples
  // each bit mid-high, then clocks it out. Optionally ACKs on the 11th bit,
  // or pulses reset shortly after fall number rst_at_fall.
  task automatic device_xfer(input bit do_ack, input int rst_at_fall,
                             input logic exp_drive_at_rst, output logic [10:0] bits);
    int t;
    bits = '0;
    t = 0;
    while (!(ps2_clk_drive == 1'b0 && ps2_data_drive == 1'b1) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      check_val("dev_start_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < 11; i++) begin
      repeat (5) @(negedge clk);
      bits[i] = ps2_data_pin;
      if (i == 10 && do_ack) dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      if (rst_at_fall == i + 1) begin
        repeat (6) @(negedge clk);
        check_val("pre_rst_data_drive", {31'd0, ps2_data_drive}, {31'd0, exp_drive_at_rst});
        check_val("pre_rst_busy", {31'd0, u_if.busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_val("rst_data_drive", {31'd0, ps2_data_drive}, 32'd0);
        check_val("rst_clk_drive", {31'd0, ps2_clk_drive}, 32'd0);
        check_val("rst_busy", {31'd0, u_if.busy}, 32'd0);
        check_val("rst_tx_ready", {31'd0, u_if.tx_ready}, 32'd1);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        return;
      end
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    repeat (10) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int t;
    t = 0;
    while (done_cnt == base && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_val(tag, done_cnt - base, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] bits;
    int          base;
    int          n;

    u_if.tx_data  = 8'h00;
    u_if.tx_valid = 1'b0;
    rst           = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_ready",      {31'd0, u_if.tx_ready}, 32'd1);
    check_val("rst_busy0",      {31'd0, u_if.busy},     32'd0);
    check_val("rst_clk_drv0",   {31'd0, ps2_clk_drive}, 32'd0);
    check_val("rst_data_drv0",  {31'd0, ps2_data_drive},32'd0);
    check_val("rst_done0",      {31'd0, u_if.done},     32'd0);
    check_val("rst_ack0",       {31'd0, u_if.ack_ok},   32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED: frame {stop=1, parity=1, ED, start=0} = 0x7DA
    base = done_cnt;
    send_byte(CMD_SET_LED);
    device_xfer(1'b1, 0, 1'b0, bits);
    wait_done(base, "ed_done");
    check_val("ed_frame", {21'd0, bits}, 32'h7DA);
    check_val("ed_inhibit_len", last_clk_run, 32'd20);
    check_val("ed_ack", {31'd0, last_ack}, 32'd1);
    @(negedge clk);
    check_val("ed_ready_after", {31'd0, u_if.tx_ready}, 32'd1);

    // 0x01: parity 0 -> 0x402
    base = done_cnt;
    send_byte(8'h01);
    device_xfer(1'b1, 0, 1'b0, bits);
    wait_done(base, "x01_done");
    check_val("x01_frame", {21'd0, bits}, 32'h402);
    check_val("x01_ack", {31'd0, last_ack}, 32'd1);

    // 0xFF: parity 1 -> 0x7FE
    base = done_cnt;
    send_byte(CMD_RESET);
    device_xfer(1'b1, 0, 1'b0, bits);
    wait_done(base, "xff_done");
    check_val("xff_frame", {21'd0, bits}, 32'h7FE);
    check_val("xff_ack", {31'd0, last_ack}, 32'd1);

    // Silent device: timeout 200 cycles after clock release
    repeat (5) @(negedge clk);
    send_byte(CMD_ENABLE);
    n = 0;
    while (!ps2_clk_drive && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (ps2_clk_drive && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!u_if.done && n < 1000) begin @(negedge clk); n++; end
    check_val("to_latency", n, 32'd200);
    check_val("to_ack", {31'd0, u_if.ack_ok}, 32'd0);
    check_val("to_clk_drv", {31'd0, ps2_clk_drive}, 32'd0);
    check_val("to_data_drv", {31'd0, ps2_data_drive}, 32'd0);
    repeat (5) @(negedge clk);

    // NACK on 0xF4 (parity 0 -> 0x5E8), then a normal 0xFF
    base = done_cnt;
    send_byte(CMD_ENABLE);
    device_xfer(1'b0, 0, 1'b0, bits);
    wait_done(base, "nack_done");
    check_val("nack_frame", {21'd0, bits}, 32'h5E8);
    check_val("nack_ack", {31'd0, last_ack}, 32'd0);
    base = done_cnt;
    send_byte(CMD_RESET);
    device_xfer(1'b1, 0, 1'b0, bits);
    wait_done(base, "post_nack_done");
    check_val("post_nack_frame", {21'd0, bits}, 32'h7FE);
    check_val("post_nack_ack", {31'd0, last_ack}, 32'd1);

    // Reset during fall 5 of 0xED: d4 = 0 is on the wire (drive = 1)
    repeat (5) @(negedge clk);
    base = done_cnt;
    send_byte(CMD_SET_LED);
    device_xfer(1'b1, 5, 1'b1, bits);
    repeat (50) @(negedge clk);
    check_val("rst_no_done", done_cnt - base, 32'd0);
    base = done_cnt;
    send_byte(CMD_ENABLE);
    device_xfer(1'b1, 0, 1'b0, bits);
    wait_done(base, "post_rst_done");
    check_val("post_rst_frame", {21'd0, bits}, 32'h5E8);
    check_val("post_rst_ack", {31'd0, last_ack}, 32'd1);

    // 0x55 offered while busy must be dropped
    repeat (5) @(negedge clk);
    base = done_cnt;
    send_byte(8'h01);
    repeat (2) @(negedge clk);
    check_val("busy_ready", {31'd0, u_if.tx_ready}, 32'd0);
    u_if.tx_data  = 8'h55;
    u_if.tx_valid = 1'b1;
    repeat (4) @(negedge clk);
    u_if.tx_valid = 1'b0;
    device_xfer(1'b1, 0, 1'b0, bits);
    wait_done(base, "busy_done");
    check_val("busy_frame", {21'd0, bits}, 32'h402);
    repeat (60) @(negedge clk);
    check_val("busy_one_done", done_cnt - base, 32'd1);
    check_val("busy_idle_after", {31'd0, u_if.busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
